// File: rtl/line_buffer_window.sv
// Purpose : 3x3 window former; four rotating line RAMs feed the convolution stage.
// Latency : window registered 1 clock after its READ cycle; o_intr marks the last window of a line.
// Backpressure: none downstream; pixels arriving while all four lines are full are dropped.
//
// Ports:
//   i_clk, i_rst                       rising-edge clock, async active-high reset
//   i_pixel_data[7:0], _valid          raster pixel stream, one pixel per valid cycle
//   o_pixel_data[71:0], _valid         window, byte 3*row+col, row 0 = oldest line, col 0 = left
//   o_intr                             one-cycle pulse: a line was consumed, its slot is free
//
// Build option: define WINDOW_ZERO_PAD_EN to output 0x00 for columns past the
// right edge instead of replicating the last pixel. Timing is unaffected.

module line_buffer_window #(
  parameter int IMG_WIDTH = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  localparam int CNT_W = $clog2(4*IMG_WIDTH+1);
  localparam int PTR_W = $clog2(IMG_WIDTH);
  localparam int COL_W = PTR_W + 1;   // holds rd_ptr+2 without overflow

  localparam logic [CNT_W-1:0] TOTAL_FULL   = CNT_W'(4*IMG_WIDTH);
  localparam logic [CNT_W-1:0] TOTAL_THRESH = CNT_W'(3*IMG_WIDTH);
  localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(IMG_WIDTH-1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

`ifdef WINDOW_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  // line storage, not reset
  logic [7:0]       r_mem [4][IMG_WIDTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [1:0]       r_wr_line;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [1:0]       r_rd_line;
  logic [CNT_W-1:0] r_total;
  logic [0:0]       r_state;
  logic [71:0]      r_pixel_data;
  logic             r_pixel_data_valid;
  logic             r_intr;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [COL_W-1:0] w_col_sum  [3];
  logic             w_col_ovf  [3];
  logic [PTR_W-1:0] w_col_addr [3];
  logic [71:0]      w_window;

  // a full set of four lines means the next write would clobber unread data
  assign w_wr_en = i_pixel_data_valid && (r_total != TOTAL_FULL);
  assign w_rd_en = (r_state == ST_READ);

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_line][r_wr_ptr] <= i_pixel_data;
    end
  end

  // column addresses, clamped at the right edge
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_col_sum[c]  = {1'b0, r_rd_ptr} + COL_W'(c);
      w_col_ovf[c]  = (w_col_sum[c] > COL_W'(IMG_WIDTH-1));
      w_col_addr[c] = w_col_ovf[c] ? PTR_LAST : w_col_sum[c][PTR_W-1:0];
    end
  end

  // nine read taps: three rows (rotating line index) by three columns
  always_comb begin
    w_window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (ZERO_PAD && w_col_ovf[c]) begin
          w_window[8*(3*r+c) +: 8] = 8'h00;
        end else begin
          w_window[8*(3*r+c) +: 8] = r_mem[2'(r_rd_line + 2'(r))][w_col_addr[c]];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr           <= '0;
      r_wr_line          <= '0;
      r_rd_ptr           <= '0;
      r_rd_line          <= '0;
      r_total            <= '0;
      r_state            <= ST_IDLE;
      r_pixel_data       <= '0;
      r_pixel_data_valid <= 1'b0;
      r_intr             <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_ptr == PTR_LAST) begin
          r_wr_ptr  <= '0;
          r_wr_line <= r_wr_line + 2'd1;
        end else begin
          r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        end
      end

      // simultaneous write and read cancel out
      case ({w_wr_en, w_rd_en})
        2'b10:   r_total <= r_total + CNT_W'(1);
        2'b01:   r_total <= r_total - CNT_W'(1);
        default: r_total <= r_total;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (r_total >= TOTAL_THRESH) begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (r_rd_ptr == PTR_LAST) begin
            r_rd_ptr  <= '0;
            r_rd_line <= r_rd_line + 2'd1;
            r_state   <= ST_IDLE;
          end else begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // window register doubles as the RAM read register; holds when idle
      if (w_rd_en) begin
        r_pixel_data <= w_window;
      end
      r_pixel_data_valid <= w_rd_en;
      r_intr             <= w_rd_en && (r_rd_ptr == PTR_LAST);
    end
  end

  assign o_pixel_data       = r_pixel_data;
  assign o_pixel_data_valid = r_pixel_data_valid;
  assign o_intr             = r_intr;

endmodule

// File: tb/tb_line_buffer_window.sv
// Purpose : directed bench for line_buffer_window at IMG_WIDTH = 8, pixel = line*16 + col.
// Latency : windows and interrupt positions are collected on the falling edge and compared.
// Backpressure: not exercised beyond the continuous 40-pixel stream.

module tb_line_buffer_window;

  localparam int W = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [7:0]  i_pixel_data = 8'h00;
  logic        i_pixel_data_valid = 1'b0;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;
  int max_total = 0;

  logic [71:0] win_q[$];
  int          stamp_q[$];
  int          intr_q[$];
  int          intr_novld = 0;

  line_buffer_window #(.IMG_WIDTH(W)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  always begin
    #5;
    if (clk_en) i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_pixel_data_valid) begin
      win_q.push_back(o_pixel_data);
      stamp_q.push_back(cyc);
    end
    if (o_intr) begin
      if (o_pixel_data_valid) intr_q.push_back(win_q.size() - 1);
      else intr_novld++;
    end
    if (int'(dut.r_total) > max_total) max_total = int'(dut.r_total);
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win_at(input int i);
    if (i < win_q.size()) return win_q[i];
    return 'x;
  endfunction

  function automatic logic [7:0] pix(input int n);
    return 8'((n / W) * 16 + (n % W));
  endfunction

  task automatic send(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_pixel_data       = pix(first + i);
      i_pixel_data_valid = 1'b1;
    end
    @(negedge i_clk);
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic clear_obs();
    win_q.delete();
    stamp_q.delete();
    intr_q.delete();
    intr_novld = 0;
    max_total  = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    clear_obs();
  endtask

  task automatic wait_win(input int n, input int budget);
    int k;
    k = 0;
    #1;
    while (win_q.size() < n && k < budget) begin
      @(negedge i_clk);
      #1;
      k++;
    end
  endtask

  initial begin
    // reset with the clock stopped
    #1 i_rst = 1'b1;
    #1;
    check("rst_data", o_pixel_data, 72'h0);
    check("rst_vld",  {71'h0, o_pixel_data_valid}, 72'h0);
    check("rst_intr", {71'h0, o_intr}, 72'h0);
    clk_en = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    clear_obs();

    // three lines, first read
    send(0, 23);
    idle(6);
    check("no_out_23", 72'(win_q.size()), 72'd0);
    send(23, 1);
    wait_win(8, 40);
    idle(4);
    check("l1_count",  72'(win_q.size()), 72'd8);
    check("l1_win0",   win_at(0), 72'h22_21_20_12_11_10_02_01_00);
`ifdef WINDOW_ZERO_PAD_EN
    check("l1_win6",   win_at(6), 72'h00_27_26_00_17_16_00_07_06);
    check("l1_win7",   win_at(7), 72'h00_00_27_00_00_17_00_00_07);
    check("l1_hold",   o_pixel_data, 72'h00_00_27_00_00_17_00_00_07);
`else
    check("l1_win6",   win_at(6), 72'h27_27_26_17_17_16_07_07_06);
    check("l1_win7",   win_at(7), 72'h27_27_27_17_17_17_07_07_07);
    check("l1_hold",   o_pixel_data, 72'h27_27_27_17_17_17_07_07_07);
`endif
    check("l1_contig", 72'((stamp_q.size() == 8) ? stamp_q[7] - stamp_q[0] : -1), 72'd7);
    check("l1_intr_n", 72'(intr_q.size()), 72'd1);
    check("l1_intr_at", 72'((intr_q.size() > 0) ? intr_q[0] : -1), 72'd7);
    check("l1_intr_nv", 72'(intr_novld), 72'd0);

    // continuous stream of five lines
    do_reset();
    check("rst2_data", o_pixel_data, 72'h0);
    send(0, 40);
    wait_win(24, 120);
    idle(20);
    check("s_count",   72'(win_q.size()), 72'd24);
    check("s_win8",    win_at(8),  72'h32_31_30_22_21_20_12_11_10);
    check("s_win16",   win_at(16), 72'h42_41_40_32_31_30_22_21_20);
`ifdef WINDOW_ZERO_PAD_EN
    check("s_win15",   win_at(15), 72'h00_00_37_00_00_27_00_00_17);
`else
    check("s_win15",   win_at(15), 72'h37_37_37_27_27_27_17_17_17);
`endif
    check("s_max_tot", 72'(max_total), 72'd26);
    check("s_intr_n",  72'(intr_q.size()), 72'd3);
    check("s_intr_2",  72'((intr_q.size() > 1) ? intr_q[1] : -1), 72'd15);
    check("s_rem_tot", 72'(int'(dut.r_total)), 72'd16);

    // reset in the middle of a read
    do_reset();
    send(0, 24);
    wait_win(4, 40);
    check("m_pre4",    72'(win_q.size()), 72'd4);
    i_rst = 1'b1;
    #1;
    check("m_vld_drop", {71'h0, o_pixel_data_valid}, 72'h0);
    check("m_intr",     {71'h0, o_intr}, 72'h0);
    check("m_intr_n",   72'(intr_q.size() + intr_novld), 72'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    clear_obs();
    idle(4);
    send(0, 23);
    idle(6);
    check("m_no_out",  72'(win_q.size()), 72'd0);
    send(23, 1);
    wait_win(8, 40);
    idle(4);
    check("m_count",   72'(win_q.size()), 72'd8);
    check("m_win0",    win_at(0), 72'h22_21_20_12_11_10_02_01_00);
    check("m_win3",    win_at(3), 72'h25_24_23_15_14_13_05_04_03);
    check("m_intr_at", 72'((intr_q.size() == 1) ? intr_q[0] : -1), 72'd7);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/line_buffer_window.md
Name: line_buffer_window

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Takes a raster pixel stream of 8 bits per cycle and stores it in four rotating line buffers.
- Once three full lines are stored, emits one 72-bit 3x3 window per cycle for a full line, then pulses an interrupt so the host can send the next line.

Parameters:
- IMG_WIDTH, 512, pixels per line. Legal range 4..4096.
- CNT_W, $clog2(4*IMG_WIDTH+1), width of the stored-pixel counter. Derived; do not override.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_pixel_data  in  8  input pixel, unsigned.
- i_pixel_data_valid  in  1  input pixel qualifier; one pixel is written per cycle it is high.
- o_pixel_data  out  72  3x3 window; byte i = o_pixel_data[8*i+:8], i = 3*row+col, row 0 = oldest (top) line, col 0 = leftmost.
- o_pixel_data_valid  out  1  window qualifier.
- o_intr  out  1  single-cycle pulse: one line consumed, buffer slot freed.

Behaviour:
- Storage:
  - 4 line RAMs of IMG_WIDTH x 8, synchronous read.
  - Contents are not reset.
- Write side:
  - On each valid pixel, write to RAM wr_line at address wr_ptr, then increment wr_ptr.
  - When wr_ptr = IMG_WIDTH-1 it wraps to 0 and wr_line increments mod 4.
- Counter:
  - total counts stored but unconsumed pixels: +1 per accepted write, -1 per READ cycle.
  - A write and a READ in the same cycle leave total unchanged.
  - If total = 4*IMG_WIDTH, an incoming write is dropped; pointers and total do not change.
- FSM states: IDLE, READ. Reset state is IDLE.
  - IDLE -> READ when total >= 3*IMG_WIDTH (registered; READ begins the cycle after the condition is seen).
  - READ lasts exactly IMG_WIDTH cycles, with rd_ptr = 0..IMG_WIDTH-1.
  - After rd_ptr = IMG_WIDTH-1: rd_ptr <- 0, rd_line <- rd_line+1 mod 4, state -> IDLE.
  - IDLE always lasts at least 1 cycle between reads.
- Window formation:
  - Rows come from RAMs rd_line, rd_line+1, rd_line+2 (mod 4).
  - Columns are rd_ptr, rd_ptr+1, rd_ptr+2; any column > IMG_WIDTH-1 is clamped to IMG_WIDTH-1 (right-edge replicate).
  - Each row needs 3 bytes per cycle; implement as 3 read ports per RAM or an equivalent shift structure. Output timing must not change with the choice.
- Latency and output timing:
  - o_pixel_data and o_pixel_data_valid are registered and lag their READ cycle by exactly 1 clock.
  - o_pixel_data_valid is therefore high for IMG_WIDTH consecutive cycles per line.
  - o_intr is high for exactly 1 cycle, coincident with the last valid window of the line.
  - o_pixel_data holds its last value when valid is low.
- Reset (async):
  - Outputs o_pixel_data = 0, o_pixel_data_valid = 0, o_intr = 0.
  - Internally: wr_ptr, rd_ptr, wr_line, rd_line = 0; total = 0; state = IDLE.
  - Reset asserted mid-READ aborts the line immediately; no o_intr.
  - After release, 3 full lines must be written again before any output.

Optional Feature:
- WINDOW_ZERO_PAD_EN defined: window columns > IMG_WIDTH-1 output 0x00 instead of the clamped pixel.
- Undefined: right-edge replicate, as above.
- Timing is identical either way.

Test Plan (IMG_WIDTH = 8, pixel value = line*16 + col):
- Reset: assert i_rst with no clock running -> all outputs 0 immediately. Then 23 pixels -> o_pixel_data_valid stays 0.
- Feed 24 pixels (lines 0-2) -> valid high for 8 consecutive cycles; first window = 72'h22_21_20_12_11_10_02_01_00.
- Same run, edge windows:
  - rd_ptr = 6 window = 72'h27_27_26_17_17_16_07_07_06.
  - rd_ptr = 7 window = 72'h27_27_27_17_17_17_07_07_07; o_intr high in this cycle only.
  - With WINDOW_ZERO_PAD_EN, rd_ptr = 7 window = 72'h00_00_27_00_00_17_00_00_07.
- Continuous stream of 40 pixels (lines 0-4), valid every cycle:
  - second read outputs rows = lines 1,2,3; first window = 72'h32_31_30_22_21_20_12_11_10;
  - total never exceeds 26; no write dropped.
- Assert i_rst during the 4th valid window of a read -> valid drops at once, no o_intr. Then 23 new pixels -> no output; the 24th pixel starts a fresh read from line 0 data.
